hilo_seq: RTL and testbench
===========================

Name: hilo_seq

Overview:
- Sequencer and HI/LO holding registers directly downstream of the mult block.
- The control unit issues a one-cycle multiply request. hilo_seq then:
  - drives the level MultCtrl into mult;
  - waits for MultDone;
  - latches mult's HI/LO into architectural HI/LO registers.
- Provides Busy as a stall to the control unit, mthi/mtlo writes, and mfhi/mflo read data.
- A cycle-count watchdog flags a multiply that never completes.

Parameters:
- TIMEOUT_CYCLES, 40, RUN cycles allowed before abort. Must be ≥ 2; mult worst case is 32–34 cycles.
- WIDTH, 32, data width of HI, LO and WrData.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- MultStart  in  1  one-cycle multiply request from control unit
- MultDone  in  1  completion flag from mult
- MultHI  in  WIDTH  mult HI result
- MultLO  in  WIDTH  mult LO result
- MthiWr  in  1  mthi write strobe
- MtloWr  in  1  mtlo write strobe
- WrData  in  WIDTH  rs data for mthi/mtlo
- MultCtrl  out  1  registered level enable to mult
- HIOut  out  WIDTH  architectural HI (mfhi source)
- LOOut  out  WIDTH  architectural LO (mflo source)
- Busy  out  1  stall request; high whenever state != IDLE
- ResultValid  out  1  one-cycle pulse: HI/LO just updated from mult
- MultTimeout  out  1  sticky watchdog error flag

Behaviour:
- Reset (sampled on clk edge, any state):
  - state=IDLE, HIOut=0, LOOut=0, MultCtrl=0, ResultValid=0, MultTimeout=0, counter=0.
  - Reset mid-RUN aborts the operation; MultCtrl is low from the next cycle.
- States: IDLE, RUN, DONE. All outputs are registered or decoded from the state register only; there are no input-to-output combinational paths.
- IDLE:
  - MultStart=1 → RUN next cycle, MultCtrl=1, counter=0, MultTimeout cleared.
  - MultDone is ignored.
- RUN:
  - MultCtrl is held at 1; counter increments each cycle.
  - MultDone=1 on edge k → HIOut←MultHI, LOOut←MultLO at edge k; state=DONE; MultCtrl=0.
  - Else, if counter == TIMEOUT_CYCLES-1 → IDLE, MultCtrl=0, MultTimeout=1, HI/LO unchanged.
  - If MultDone and the timeout expire on the same edge, MultDone wins: result is latched, no timeout.
- DONE:
  - Exactly one cycle; ResultValid=1, Busy=1.
  - Then → IDLE unconditionally.
- Latency: MultStart at edge n → MultCtrl high from n+1. The mult result is visible on HIOut/LOOut the cycle after MultDone is sampled. Busy drops 2 cycles after MultDone is sampled.
- Busy rules:
  - MultStart while Busy=1 is ignored; no queueing, since the control unit stalls on Busy.
  - MthiWr/MtloWr while Busy=1 are ignored.
- Writes in IDLE:
  - MthiWr → HIOut←WrData next edge.
  - MtloWr → LOOut←WrData next edge.
  - Both strobes together write both registers.
  - MultStart together with MthiWr/MtloWr in IDLE: the write is performed and RUN is entered; the later mult result overwrites it.
- MultTimeout stays high until reset or the next accepted MultStart.
- The counter is WIDTH-independent: $clog2(TIMEOUT_CYCLES) bits, saturating, and never wraps while in RUN.

Decomposition:
- Shared package hilo_pkg:
  - state enum/localparams IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - default TIMEOUT_CYCLES constant, shared with the future div sequencer.
- One sub-module, hilo_watchdog: counter with clear/enable inputs and an expire output, reused later for div.

Test Plan:
1. RegA=32'hFFFFFFFB, RegB=3, MultStart pulse, real mult instantiated → MultCtrl high the next cycle; after MultDone, HIOut=32'hFFFFFFFF, LOOut=32'hFFFFFFF1, one ResultValid pulse, Busy low 2 cycles after MultDone.
2. IDLE, MthiWr=1 WrData=32'h12345678, then MtloWr=1 WrData=32'hCAFEBABE → HIOut=32'h12345678, LOOut=32'hCAFEBABE; Busy stays 0.
3. During RUN, pulse MultStart and MthiWr WrData=32'hDEADBEEF → no restart, HIOut is not DEADBEEF, final HI/LO equals the first mult result.
4. Stub mult with MultDone tied 0, TIMEOUT_CYCLES=40 → exactly 40 cycles of MultCtrl=1, then IDLE, MultTimeout=1, HI/LO keep prior values; the next MultStart clears MultTimeout.
5. MultDone asserted on the final counter cycle (cycle 40) → result latched, MultTimeout=0, ResultValid=1.
6. Reset asserted 10 cycles into RUN → next edge: IDLE, MultCtrl=0, HIOut=LOOut=0, Busy=0; a later -5*3 run completes correctly.

Source files
------------

// File: rtl/hilo_pkg.sv
// hilo_pkg: shared definitions for the HI/LO sequencers (mult today, div later).
//   hilo_state_e         - sequencer state encoding (IDLE/RUN/DONE)
//   HILO_TIMEOUT_CYCLES  - default watchdog limit in RUN cycles
package hilo_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } hilo_state_e;

    // Mult worst case is 32-34 cycles; leave a few cycles of margin.
    localparam int HILO_TIMEOUT_CYCLES = 40;

endpackage

// File: rtl/hilo_watchdog.sv
// hilo_watchdog: saturating cycle counter for a long-latency operation.
//   clk, reset  - clock, synchronous active-high reset
//   clr         - force the count back to zero (has priority over en)
//   en          - count this cycle
//   expire      - high while enabled and on the last allowed cycle
//                 (the LIMIT-th enabled cycle since clear)
module hilo_watchdog
    import hilo_pkg::*;
#(
    parameter int LIMIT = HILO_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Saturates at LAST so the count can never wrap back to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (en && (cnt_q != LAST))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign expire = en && (cnt_q == LAST);

endmodule

// File: rtl/hilo_seq.sv
// hilo_seq: multiply sequencer and architectural HI/LO registers.
//   clk, reset        - clock, synchronous active-high reset
//   MultStart         - one-cycle multiply request (ignored while Busy)
//   MultDone          - completion flag from mult (only looked at in RUN)
//   MultHI/MultLO     - mult result, latched on the MultDone edge
//   MthiWr/MtloWr     - mthi/mtlo write strobes with WrData (IDLE only)
//   MultCtrl          - registered level enable to mult, high throughout RUN
//   HIOut/LOOut       - architectural HI/LO
//   Busy              - stall to the control unit, high outside IDLE
//   ResultValid       - one-cycle pulse in DONE after HI/LO took mult's result
//   MultTimeout       - sticky: the last multiply was aborted by the watchdog
module hilo_seq
    import hilo_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = HILO_TIMEOUT_CYCLES,
    parameter int WIDTH          = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             MultStart,
    input  logic             MultDone,
    input  logic [WIDTH-1:0] MultHI,
    input  logic [WIDTH-1:0] MultLO,
    input  logic             MthiWr,
    input  logic             MtloWr,
    input  logic [WIDTH-1:0] WrData,
    output logic             MultCtrl,
    output logic [WIDTH-1:0] HIOut,
    output logic [WIDTH-1:0] LOOut,
    output logic             Busy,
    output logic             ResultValid,
    output logic             MultTimeout
);

    hilo_state_e      state_q, state_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             mult_ctrl_q, mult_ctrl_d;
    logic             timeout_q, timeout_d;
    logic             wd_expire;

    // Counter runs only in RUN and is held at zero otherwise, so every
    // RUN entry starts from a fresh count.
    hilo_watchdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .clr    (state_q != RUN),
        .en     (state_q == RUN),
        .expire (wd_expire)
    );

    always_comb begin
        state_d   = state_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        timeout_d = timeout_q;
        unique case (state_q)
            IDLE: begin
                // Writes and a start may coincide; the write lands now and
                // the mult result overwrites it later.
                if (MthiWr) hi_d = WrData;
                if (MtloWr) lo_d = WrData;
                if (MultStart) begin
                    state_d   = RUN;
                    timeout_d = 1'b0;
                end
            end
            RUN: begin
                // Done beats a simultaneous watchdog expiry.
                if (MultDone) begin
                    hi_d    = MultHI;
                    lo_d    = MultLO;
                    state_d = DONE;
                end else if (wd_expire) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        mult_ctrl_d = (state_d == RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            hi_q        <= '0;
            lo_q        <= '0;
            mult_ctrl_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            mult_ctrl_q <= mult_ctrl_d;
            timeout_q   <= timeout_d;
        end
    end

    assign MultCtrl    = mult_ctrl_q;
    assign HIOut       = hi_q;
    assign LOOut       = lo_q;
    assign Busy        = (state_q != IDLE);
    assign ResultValid = (state_q == DONE);
    assign MultTimeout = timeout_q;

endmodule

// File: tb/tb_hilo_seq.sv
// tb_hilo_seq: directed bench for hilo_seq with a behavioural mult stand-in
// and a cycle-level reference model compared on every negative edge.
module tb_hilo_seq;

    localparam int TO = 40;
    localparam int W  = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         MultStart = 1'b0;
    logic         MthiWr = 1'b0;
    logic         MtloWr = 1'b0;
    logic [W-1:0] WrData = '0;
    logic         MultDone;
    logic [W-1:0] MultHI, MultLO;
    logic         MultCtrl, Busy, ResultValid, MultTimeout;
    logic [W-1:0] HIOut, LOOut;

    hilo_seq #(.TIMEOUT_CYCLES(TO), .WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .MultStart   (MultStart),
        .MultDone    (MultDone),
        .MultHI      (MultHI),
        .MultLO      (MultLO),
        .MthiWr      (MthiWr),
        .MtloWr      (MtloWr),
        .WrData      (WrData),
        .MultCtrl    (MultCtrl),
        .HIOut       (HIOut),
        .LOOut       (LOOut),
        .Busy        (Busy),
        .ResultValid (ResultValid),
        .MultTimeout (MultTimeout)
    );

    always #5 clk = ~clk;

    // Mult stand-in: signed 32x32 product, MultDone raised on the
    // done_at-th cycle (0-based) of MultCtrl being high.
    logic signed [63:0] ma = 64'sd0, mb = 64'sd0;
    logic signed [63:0] prod;
    int                 done_at = 31;
    int                 mcnt = 0;
    assign prod     = ma * mb;
    assign MultHI   = prod[63:32];
    assign MultLO   = prod[31:0];
    assign MultDone = MultCtrl && (mcnt == done_at);
    always @(posedge clk) mcnt <= MultCtrl ? mcnt + 1 : 0;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 = waiting, 1 = multiplying, 2 = result cycle.
    int           m_phase = 0;
    int           m_age = 0;
    logic [W-1:0] m_hi = '0, m_lo = '0;
    bit           m_to = 1'b0;

    initial forever begin
        @(posedge clk);
        if (reset) begin
            m_phase = 0; m_age = 0; m_hi = '0; m_lo = '0; m_to = 1'b0;
        end else if (m_phase == 0) begin
            if (MthiWr) m_hi = WrData;
            if (MtloWr) m_lo = WrData;
            if (MultStart) begin m_phase = 1; m_age = 0; m_to = 1'b0; end
        end else if (m_phase == 1) begin
            if (MultDone) begin
                m_hi = MultHI; m_lo = MultLO; m_phase = 2;
            end else if (m_age + 1 >= TO) begin
                m_phase = 0; m_to = 1'b1;
            end else begin
                m_age++;
            end
        end else begin
            m_phase = 0;
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("model_busy",  {63'd0, Busy},        {63'd0, m_phase != 0});
            chk("model_ctrl",  {63'd0, MultCtrl},    {63'd0, m_phase == 1});
            chk("model_rv",    {63'd0, ResultValid}, {63'd0, m_phase == 2});
            chk("model_to",    {63'd0, MultTimeout}, {63'd0, m_to});
            chk("model_hi",    {32'd0, HIOut},       {32'd0, m_hi});
            chk("model_lo",    {32'd0, LOOut},       {32'd0, m_lo});
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic start_mult(input longint a, input longint b);
        ma = a; mb = b;
        MultStart = 1'b1;
        step();
        MultStart = 1'b0;
    endtask

    // Steps until the edge that samples MultDone has passed.
    task automatic run_until_done(input string name);
        for (int i = 0; i < 100; i++) begin
            if (MultDone) begin
                step();
                return;
            end
            step();
        end
        chk({name, "_done_timeout"}, 64'd0, 64'd1);
    endtask

    initial begin
        int n;
        step(); step();
        reset = 1'b0;
        chk_en = 1'b1;
        chk("rst_hi", HIOut, 64'd0);
        chk("rst_lo", LOOut, 64'd0);
        chk("rst_busy", Busy, 64'd0);
        chk("rst_ctrl", MultCtrl, 64'd0);

        // 1: -5 * 3
        done_at = 31;
        start_mult(-5, 3);
        chk("t1_ctrl", MultCtrl, 64'd1);
        chk("t1_busy", Busy, 64'd1);
        run_until_done("t1");
        chk("t1_hi", HIOut, 64'hFFFFFFFF);
        chk("t1_lo", LOOut, 64'hFFFFFFF1);
        chk("t1_rv", ResultValid, 64'd1);
        chk("t1_busy_done", Busy, 64'd1);
        step();
        chk("t1_rv_off", ResultValid, 64'd0);
        chk("t1_busy_off", Busy, 64'd0);

        // 2: mthi then mtlo
        MthiWr = 1'b1; WrData = 32'h12345678;
        step();
        MthiWr = 1'b0; MtloWr = 1'b1; WrData = 32'hCAFEBABE;
        step();
        MtloWr = 1'b0;
        chk("t2_hi", HIOut, 64'h12345678);
        chk("t2_lo", LOOut, 64'hCAFEBABE);
        chk("t2_busy", Busy, 64'd0);

        // 3: start and mthi during RUN are ignored
        start_mult(7, 6);
        step(); step(); step();
        MultStart = 1'b1; MthiWr = 1'b1; WrData = 32'hDEADBEEF;
        step();
        MultStart = 1'b0; MthiWr = 1'b0;
        chk("t3_hi_kept", HIOut, 64'h12345678);
        run_until_done("t3");
        chk("t3_hi", HIOut, 64'd0);
        chk("t3_lo", LOOut, 64'd42);
        step();

        // 4: watchdog abort
        done_at = 1000;
        start_mult(9, 9);
        n = MultCtrl ? 1 : 0;
        for (int i = 0; i < 100 && MultCtrl; i++) begin
            step();
            if (MultCtrl) n++;
        end
        chk("t4_ctrl_cycles", n, TO);
        chk("t4_to", MultTimeout, 64'd1);
        chk("t4_busy", Busy, 64'd0);
        chk("t4_hi", HIOut, 64'd0);
        chk("t4_lo", LOOut, 64'd42);
        step();
        chk("t4_to_sticky", MultTimeout, 64'd1);
        done_at = 31;
        start_mult(2, 3);
        chk("t4_to_clr", MultTimeout, 64'd0);
        run_until_done("t4");
        chk("t4_lo_after", LOOut, 64'd6);
        step();

        // 5: done on the last watchdog cycle wins
        done_at = TO - 1;
        start_mult(-1, -1);
        run_until_done("t5");
        chk("t5_to", MultTimeout, 64'd0);
        chk("t5_rv", ResultValid, 64'd1);
        chk("t5_hi", HIOut, 64'd0);
        chk("t5_lo", LOOut, 64'd1);
        step();

        // 6: reset mid-RUN, then a clean -5*3
        done_at = 31;
        start_mult(100, 100);
        for (int i = 0; i < 9; i++) step();
        reset = 1'b1;
        step();
        chk("t6_ctrl", MultCtrl, 64'd0);
        chk("t6_busy", Busy, 64'd0);
        chk("t6_hi", HIOut, 64'd0);
        chk("t6_lo", LOOut, 64'd0);
        reset = 1'b0;
        step();
        start_mult(-5, 3);
        run_until_done("t6");
        chk("t6_hi_res", HIOut, 64'hFFFFFFFF);
        chk("t6_lo_res", LOOut, 64'hFFFFFFF1);
        step(); step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
